// File: rtl/id_ex_reg_if.sv
// Pipeline stage bundle: valid/ready handshake plus the decoded-instruction payload.
// master drives valid and payload; slave returns ready.
interface id_ex_reg_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [10:0] ctrl;

  modport master (
    output valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3, ctrl,
    input  ready
  );

  modport slave (
    input  valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3, ctrl,
    output ready
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and a saturating
// stall counter.
module id_ex_reg (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_reg_if.slave  id,
  id_ex_reg_if.master ex,
  input  logic        flush,
  output logic [15:0] stall_count
);
  logic        ex_valid_q;
  logic [31:0] ex_pc_q;
  logic [31:0] ex_rs1_data_q;
  logic [31:0] ex_rs2_data_q;
  logic [31:0] ex_imm_q;
  logic [4:0]  ex_rs1_q;
  logic [4:0]  ex_rs2_q;
  logic [4:0]  ex_rd_q;
  logic [2:0]  ex_funct3_q;
  logic [10:0] ex_ctrl_q;
  logic [15:0] stall_cnt_q;

  logic advance;
  logic hazard;

  always_comb begin
    advance = !ex_valid_q || ex.ready;
    // Load in EX whose result a dependent instruction in ID needs right now.
    hazard  = ex_valid_q && ex_ctrl_q[7] && (ex_rd_q != 5'd0) && id.valid &&
              ((ex_rd_q == id.rs1) || (ex_rd_q == id.rs2));
    id.ready = advance && (!hazard || flush);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_funct3_q   <= '0;
      ex_ctrl_q     <= '0;
      stall_cnt_q   <= '0;
    end else if (advance) begin
      if (flush) begin
        ex_valid_q <= 1'b0;
        ex_ctrl_q  <= '0;
      end else if (hazard) begin
        ex_valid_q <= 1'b0;
        ex_ctrl_q  <= '0;
        if (stall_cnt_q != 16'hFFFF) begin
          stall_cnt_q <= stall_cnt_q + 16'd1;
        end
      end else begin
        ex_valid_q    <= id.valid;
        ex_pc_q       <= id.pc;
        ex_rs1_data_q <= id.rs1_data;
        ex_rs2_data_q <= id.rs2_data;
        ex_imm_q      <= id.imm;
        ex_rs1_q      <= id.rs1;
        ex_rs2_q      <= id.rs2;
        ex_rd_q       <= id.rd;
        ex_funct3_q   <= id.funct3;
        ex_ctrl_q     <= id.valid ? id.ctrl : '0;
      end
    end
  end

  assign ex.valid    = ex_valid_q;
  assign ex.pc       = ex_pc_q;
  assign ex.rs1_data = ex_rs1_data_q;
  assign ex.rs2_data = ex_rs2_data_q;
  assign ex.imm      = ex_imm_q;
  assign ex.rs1      = ex_rs1_q;
  assign ex.rs2      = ex_rs2_q;
  assign ex.rd       = ex_rd_q;
  assign ex.funct3   = ex_funct3_q;
  assign ex.ctrl     = ex_ctrl_q;
  assign stall_count = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: pass-through, load-use bubbles, x0, backpressure,
// flush priority, counter saturation and reset.
module tb_id_ex_reg;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] stall_count;
  int unsigned n_checks;
  int unsigned n_fails;

  id_ex_reg_if id_bus ();
  id_ex_reg_if ex_bus ();

  id_ex_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id          (id_bus),
    .ex          (ex_bus),
    .flush       (flush),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [31:0] pc, input logic [10:0] ctrl,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_bus.valid    = v;
    id_bus.pc       = pc;
    id_bus.ctrl     = ctrl;
    id_bus.rs1      = rs1;
    id_bus.rs2      = rs2;
    id_bus.rd       = rd;
    id_bus.rs1_data = pc ^ 32'hA5A5_0000;
    id_bus.rs2_data = pc ^ 32'h5A5A_0000;
    id_bus.imm      = pc + 32'd4;
    id_bus.funct3   = pc[4:2];
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    ex_bus.ready = 1'b1;
    present(1'b1, 32'h0000_0DEF, 11'h7FF, 5'd3, 5'd4, 5'd7);
    step();
    step();
    check("rst_ex_valid", {31'd0, ex_bus.valid}, 32'd0);
    check("rst_ex_ctrl", {21'd0, ex_bus.ctrl}, 32'd0);
    check("rst_ex_pc", ex_bus.pc, 32'd0);
    check("rst_ex_rd", {27'd0, ex_bus.rd}, 32'd0);
    check("rst_stall", {16'd0, stall_count}, 32'd0);
    check("rst_id_ready", {31'd0, id_bus.ready}, 32'd1);

    // pass-through
    rst_n = 1'b1;
    present(1'b1, 32'h100, 11'h400, 5'd1, 5'd2, 5'd3);
    step();
    check("pt_ex_valid", {31'd0, ex_bus.valid}, 32'd1);
    check("pt_ex_pc", ex_bus.pc, 32'h100);
    check("pt_ex_ctrl", {21'd0, ex_bus.ctrl}, 32'h400);
    check("pt_ex_rd", {27'd0, ex_bus.rd}, 32'd3);
    check("pt_ex_imm", ex_bus.imm, 32'h104);
    check("pt_ex_rs1_data", ex_bus.rs1_data, 32'hA5A5_0100);

    // load-use on rs1
    present(1'b1, 32'h200, 11'h080, 5'd0, 5'd0, 5'd5);
    step();
    present(1'b1, 32'h204, 11'h500, 5'd5, 5'd7, 5'd6);
    check("lu_id_ready", {31'd0, id_bus.ready}, 32'd0);
    step();
    check("lu_bubble_valid", {31'd0, ex_bus.valid}, 32'd0);
    check("lu_bubble_ctrl", {21'd0, ex_bus.ctrl}, 32'd0);
    check("lu_stall", {16'd0, stall_count}, 32'd1);
    check("lu_id_ready_after", {31'd0, id_bus.ready}, 32'd1);
    step();
    check("lu_accept_valid", {31'd0, ex_bus.valid}, 32'd1);
    check("lu_accept_pc", ex_bus.pc, 32'h204);
    check("lu_accept_rd", {27'd0, ex_bus.rd}, 32'd6);

    // load writing x0 never stalls
    present(1'b1, 32'h300, 11'h080, 5'd1, 5'd2, 5'd0);
    step();
    present(1'b1, 32'h304, 11'h100, 5'd9, 5'd0, 5'd4);
    check("x0_id_ready", {31'd0, id_bus.ready}, 32'd1);
    step();
    check("x0_ex_pc", ex_bus.pc, 32'h304);
    check("x0_stall", {16'd0, stall_count}, 32'd1);

    // backpressure, flush ignored while stalled
    ex_bus.ready = 1'b0;
    present(1'b1, 32'h400, 11'h080, 5'd1, 5'd2, 5'd8);
    check("bp_id_ready0", {31'd0, id_bus.ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      step();
      check("bp_ex_valid", {31'd0, ex_bus.valid}, 32'd1);
      check("bp_ex_pc", ex_bus.pc, 32'h304);
      check("bp_ex_ctrl", {21'd0, ex_bus.ctrl}, 32'h100);
      check("bp_id_ready", {31'd0, id_bus.ready}, 32'd0);
    end
    flush = 1'b0;
    ex_bus.ready = 1'b1;
    #1;
    step();
    check("bp_release_pc", ex_bus.pc, 32'h400);
    check("bp_release_valid", {31'd0, ex_bus.valid}, 32'd1);

    // flush beats hazard
    present(1'b1, 32'h500, 11'h100, 5'd8, 5'd1, 5'd2);
    flush = 1'b1;
    #1;
    check("fh_id_ready", {31'd0, id_bus.ready}, 32'd1);
    step();
    flush = 1'b0;
    check("fh_ex_valid", {31'd0, ex_bus.valid}, 32'd0);
    check("fh_ex_ctrl", {21'd0, ex_bus.ctrl}, 32'd0);
    check("fh_stall", {16'd0, stall_count}, 32'd1);

    // invalid instruction: ctrl cleared, data still loaded
    present(1'b0, 32'h600, 11'h7FF, 5'd1, 5'd2, 5'd3);
    step();
    check("inv_ex_valid", {31'd0, ex_bus.valid}, 32'd0);
    check("inv_ex_ctrl", {21'd0, ex_bus.ctrl}, 32'd0);
    check("inv_ex_pc", ex_bus.pc, 32'h600);

    // saturation: self-dependent load gives a bubble every other cycle
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    check("sat_preload", {16'd0, stall_count}, 32'h0000_FFFE);
    present(1'b1, 32'h700, 11'h180, 5'd0, 5'd5, 5'd5);
    step();
    check("sat_load_valid", {31'd0, ex_bus.valid}, 32'd1);
    step();
    check("sat_inc", {16'd0, stall_count}, 32'h0000_FFFF);
    step();
    step();
    check("sat_hold", {16'd0, stall_count}, 32'h0000_FFFF);
    check("sat_bubble_valid", {31'd0, ex_bus.valid}, 32'd0);
    step();
    check("sat_reload_valid", {31'd0, ex_bus.valid}, 32'd1);
    check("sat_id_ready", {31'd0, id_bus.ready}, 32'd0);

    // reset mid-stall
    rst_n = 1'b0;
    step();
    check("mrst_ex_valid", {31'd0, ex_bus.valid}, 32'd0);
    check("mrst_stall", {16'd0, stall_count}, 32'd0);
    check("mrst_ex_pc", ex_bus.pc, 32'd0);
    check("mrst_ex_rd", {27'd0, ex_bus.rd}, 32'd0);
    check("mrst_ex_imm", ex_bus.imm, 32'd0);
    check("mrst_id_ready", {31'd0, id_bus.ready}, 32'd1);
    rst_n = 1'b1;
    present(1'b0, 32'h800, 11'h000, 5'd0, 5'd0, 5'd0);
    step();
    check("mrst_no_residual", {31'd0, ex_bus.valid}, 32'd0);
    check("mrst_stall_after", {16'd0, stall_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  synchronous active-low reset.
REQ-002 id_valid  input  1  decode stage presents a valid instruction.
REQ-003 id_ready  output  1  block accepts the decode-stage instruction this cycle.
REQ-004 id_pc  input  32  PC of the decoded instruction.
REQ-005 id_rs1_data, id_rs2_data, id_imm  input  32 each  register-file operands and sign-extended immediate.
REQ-006 id_rs1, id_rs2, id_rd  input  5 each  source and destination register indices.
REQ-007 id_funct3  input  3  instruction funct3.
REQ-008 id_ctrl  input  11  decode control bundle {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[3:0], jump}, bit 10 = alu_src, bit 0 = jump, so mem_read = bit 7.
REQ-009 ex_ready  input  1  execute stage can take a new instruction.
REQ-010 flush  input  1  branch/jump redirect; kill the in-flight decode instruction.
REQ-011 ex_valid  output  1  registered instruction valid to execute stage.
REQ-012 ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  32 each;  ex_rs1, ex_rs2, ex_rd  output  5 each;  ex_funct3  output  3;  ex_ctrl  output  11.  These are the registered copies of the id_* inputs.
REQ-013 stall_count  output  16  number of load-use bubbles inserted, saturating.

Function
REQ-014 advance = !ex_valid || ex_ready; the register SHALL load new contents only on a clk edge where advance=1.
REQ-015 hazard = ex_valid && ex_ctrl[7] && (ex_rd != 0) && id_valid && (ex_rd == id_rs1 || ex_rd == id_rs2); combinational.
REQ-016 id_ready = advance && (!hazard || flush); combinational, no dependency on id_valid.
REQ-017 Priority on an edge with advance=1: flush > hazard > normal load.
REQ-018 flush=1 and advance=1: ex_valid<=0, ex_ctrl<=0, and the id_* instruction is consumed and discarded; stall_count is unchanged.
REQ-019 flush=1 and advance=0: all registers SHALL hold, and the flush SHALL NOT be remembered; upstream re-asserts flush until it is accepted.
REQ-020 hazard=1, flush=0, advance=1: a bubble is inserted, so ex_valid<=0 and ex_ctrl<=0; the id_* instruction is not consumed (id_ready=0); stall_count increments by 1.
REQ-021 Normal load (no flush or hazard, advance=1): ex_valid<=id_valid and every ex_* field is loaded from its id_* field; when id_valid=0, ex_ctrl<=0.
REQ-022 advance=0: every register holds its value, and id_ready=0.
REQ-023 Invariant: ex_valid=0 implies ex_ctrl=0 at every cycle.
REQ-024 Data fields (pc, operands, imm, indices, funct3) SHALL be don't-care when ex_valid=0, but SHALL be loaded from id_* on every normal load.
REQ-025 A load-use hazard lasts exactly one bubble cycle, because after the bubble ex_valid=0 and therefore hazard=0.
REQ-026 stall_count SHALL saturate at 0xFFFF and never wrap.
REQ-027 Latency is one cycle from an accepted id_* instruction to ex_valid=1.

Reset
REQ-028 With rst_n=0 at a clk edge, the following SHALL be cleared: ex_valid=0, ex_ctrl=0, all ex_* data and index fields=0, stall_count=0.
REQ-029 Reset SHALL override flush, hazard and advance.
REQ-030 During reset, id_ready follows REQ-016 with ex_valid=0 after the first reset edge.
REQ-031 Reset asserted mid-stall SHALL discard the held instruction with no residual bubble.

Verification
REQ-032 Pass-through: id_valid=1, id_pc=0x100, id_ctrl=0x400, ex_ready=1 -> next cycle ex_valid=1, ex_pc=0x100, ex_ctrl=0x400.
REQ-033 Load-use: EX holds a load (ex_ctrl[7]=1, ex_rd=5); ID presents id_rs1=5 -> id_ready=0; next cycle ex_valid=0 and stall_count=1; the following cycle the ID instruction is accepted.
REQ-034 No hazard on x0: EX holds a load with ex_rd=0; ID presents id_rs2=0 -> id_ready=1 and no bubble.
REQ-035 Backpressure: ex_valid=1, ex_ready=0 for 3 cycles -> ex_* fields stable and id_ready=0 throughout; flush asserted during this window has no effect.
REQ-036 Flush during hazard: hazard conditions true, flush=1, ex_ready=1 -> id_ready=1, ex_valid=0 next cycle, stall_count unchanged.
REQ-037 Saturation and reset: preload stall_count=0xFFFF, then one more bubble -> stall_count stays 0xFFFF; rst_n=0 for one edge -> all outputs 0.
